// File: rtl/spm_pkg.sv
// Shared types and helpers for the spm serial multiplier controller.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SPM_DEF_WIDTH = 32;

  // One RUN cycle per serial bit of the 2*w-bit product plus the spm pipeline latency.
  function automatic int run_len(input int w, input int lat);
    return 2 * w + lat;
  endfunction

endpackage

// File: rtl/spm_piso.sv
// Parallel-in, serial-out arithmetic right shifter: sbit_o is the current LSB,
// and the sign bit refills from the top so it repeats once the operand is exhausted.
module spm_piso #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             sbit_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next shift-register contents: load wins over shift.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = din_i;
    end else if (shift_i) begin
      q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
    end else begin
      q_d = q_q;
    end
  end

  // Shift-register state.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign sbit_o = q_q[0];

endmodule

// File: rtl/spm_serial_ctrl.sv
// Operand sequencer / product collector around the spm serial-parallel multiplier.
// Optional feature: SPM_CTRL_ZERO_BYPASS_EN (zero operand skips CLEAR/RUN).
module spm_serial_ctrl
  import spm_pkg::*;
#(
  parameter int WIDTH   = SPM_DEF_WIDTH,
  parameter int SPM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               spm_rst_n,
  output logic [WIDTH-1:0]   spm_x,
  output logic               spm_y,
  input  logic               spm_p
);

  localparam int PW      = 2 * WIDTH;
  localparam int RUN_LEN = run_len(WIDTH, SPM_LAT);
  localparam int CW      = $clog2(RUN_LEN + 1);

  localparam logic [CW-1:0] CNT_SHIFT_END = CW'(PW);
  localparam logic [CW-1:0] CNT_CAP_START = CW'(SPM_LAT);
  localparam logic [CW-1:0] CNT_LAST      = CW'(RUN_LEN - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   preg_q, preg_d;
  logic [PW-1:0]   out_p_q, out_p_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            spm_rst_n_q, spm_rst_n_d;
  logic [WIDTH-1:0] spm_x_q, spm_x_d;

  logic            handshake_s;
  logic            bypass_s;
  logic            y_load_s;
  logic            y_shift_s;
  logic            y_sbit_s;

  assign handshake_s = in_valid && in_ready_q;

`ifdef SPM_CTRL_ZERO_BYPASS_EN
  assign bypass_s = (in_x == '0) || (in_y == '0);
`else
  assign bypass_s = 1'b0;
`endif

  spm_piso #(
    .WIDTH (WIDTH)
  ) u_y_piso (
    .clk     (clk),
    .rst_ni  (rst),
    .load_i  (y_load_s),
    .shift_i (y_shift_s),
    .din_i   (in_y),
    .sbit_o  (y_sbit_s)
  );

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    preg_d      = preg_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;
    spm_x_d     = spm_x_q;
    y_load_s    = 1'b0;
    y_shift_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (handshake_s && bypass_s) begin
          out_p_d     = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (handshake_s) begin
          spm_x_d  = in_x;
          y_load_s = 1'b1;
          state_d  = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q < CNT_SHIFT_END) begin
          y_shift_s = 1'b1;
        end else begin
          y_shift_s = 1'b0;
        end
        // spm_p lags spm_y by SPM_LAT, so bit k arrives at cnt = k + SPM_LAT.
        if (cnt_q >= CNT_CAP_START) begin
          preg_d = {spm_p, preg_q[PW-1:1]};
        end else begin
          preg_d = preg_q;
        end
        if (cnt_q == CNT_LAST) begin
          out_p_d     = preg_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    spm_rst_n_d = (state_d != CLEAR);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      preg_q      <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      spm_rst_n_q <= 1'b0;
      spm_x_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      preg_q      <= preg_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      spm_rst_n_q <= spm_rst_n_d;
      spm_x_q     <= spm_x_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign spm_rst_n = spm_rst_n_q;
  assign spm_x     = spm_x_q;
  assign spm_y     = y_sbit_s;

endmodule
